vscpu_prog_loader: RTL

Hardware program loader for the VSCPU system. It receives a byte stream of load records and writes the decoded 32-bit words into the shared instruction/data RAM. It holds the CPU in reset until a terminating record arrives. It sits between an external byte source (UART receiver or host bridge) and the RAM write port of `top`, and replaces direct memory preloading for on-chip bring-up.

---
 rtl/vscpu_prog_loader.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/vscpu_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module   : vscpu_prog_loader
//  Purpose  : Program loader for VSCPU. Decodes a byte stream of load records
//             (ADDR16, COUNT16, COUNT x 32-bit words, all big-endian) into
//             single-cycle RAM writes, optionally zero-fills the RAM first,
//             and holds the CPU in reset until a COUNT = 0 record arrives.
//  Ports    : clk, rst (async, active-high)
//             rx_valid / rx_data / rx_ready : byte stream handshake
//             mem_we / mem_addr / mem_wdata : RAM write port
//             cpu_rst, busy, done (sticky), err (sticky) : status
//  Revision : 1.0  initial release
// ============================================================================
module vscpu_prog_loader #(
    parameter int ADDR_W    = 14,
    parameter int CLEAR_MEM = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [3:0] {
        S_CLEAR = 4'd0,
        S_A_HI  = 4'd1,
        S_A_LO  = 4'd2,
        S_C_HI  = 4'd3,
        S_C_LO  = 4'd4,
        S_DATA  = 4'd5,
        S_DONE  = 4'd6,
        S_ERR   = 4'd7
    } state_t;

    localparam state_t c_start_state = (CLEAR_MEM != 0) ? S_CLEAR : S_A_HI;

    state_t              r_state,    w_state_nxt;
    logic [7:0]          r_hi_byte,  w_hi_byte_nxt;   // high byte of ADDR or COUNT
    logic [ADDR_W-1:0]   r_addr,     w_addr_nxt;
    logic [15:0]         r_count,    w_count_nxt;
    logic [23:0]         r_shift,    w_shift_nxt;     // first three bytes of a word
    logic [1:0]          r_idx,      w_idx_nxt;
    // One extra bit so the clear sweep spends one idle cycle after the last
    // write before the stream side opens up.
    logic [ADDR_W:0]     r_clr_cnt,  w_clr_cnt_nxt;

    logic                w_we_nxt;
    logic [ADDR_W-1:0]   w_maddr_nxt;
    logic [31:0]         w_wdata_nxt;
    logic                w_accept;
    logic [15:0]         w_addr16;
    logic                w_hi_bad;
    logic                w_lo_bad;

    assign w_accept = rx_valid & rx_ready;
    assign w_addr16 = {r_hi_byte, rx_data};
    // An address bit at or above ADDR_W makes the record unaddressable.
    assign w_hi_bad = |(16'({rx_data, 8'h00}) >> ADDR_W);
    assign w_lo_bad = |(w_addr16 >> ADDR_W);

    always_comb begin
        w_state_nxt   = r_state;
        w_hi_byte_nxt = r_hi_byte;
        w_addr_nxt    = r_addr;
        w_count_nxt   = r_count;
        w_shift_nxt   = r_shift;
        w_idx_nxt     = r_idx;
        w_clr_cnt_nxt = r_clr_cnt;
        w_we_nxt      = 1'b0;
        w_maddr_nxt   = mem_addr;
        w_wdata_nxt   = mem_wdata;

        case (r_state)
            S_CLEAR: begin
                if (!r_clr_cnt[ADDR_W]) begin
                    w_we_nxt      = 1'b1;
                    w_maddr_nxt   = r_clr_cnt[ADDR_W-1:0];
                    w_wdata_nxt   = 32'h0;
                    w_clr_cnt_nxt = r_clr_cnt + (ADDR_W+1)'(1);
                end else begin
                    w_state_nxt   = S_A_HI;
                end
            end
            S_A_HI: begin
                if (w_accept) begin
                    w_hi_byte_nxt = rx_data;
                    w_state_nxt   = w_hi_bad ? S_ERR : S_A_LO;
                end
            end
            S_A_LO: begin
                if (w_accept) begin
                    if (w_lo_bad) begin
                        w_state_nxt = S_ERR;
                    end else begin
                        w_addr_nxt  = w_addr16[ADDR_W-1:0];
                        w_state_nxt = S_C_HI;
                    end
                end
            end
            S_C_HI: begin
                if (w_accept) begin
                    w_hi_byte_nxt = rx_data;
                    w_state_nxt   = S_C_LO;
                end
            end
            S_C_LO: begin
                if (w_accept) begin
                    w_count_nxt = w_addr16;
                    w_idx_nxt   = 2'd0;
                    w_state_nxt = (w_addr16 == 16'd0) ? S_DONE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_accept) begin
                    if (r_idx == 2'd3) begin
                        w_we_nxt    = 1'b1;
                        w_maddr_nxt = r_addr;
                        w_wdata_nxt = {r_shift, rx_data};
                        w_addr_nxt  = r_addr + ADDR_W'(1);   // wraps mod 2^ADDR_W
                        w_count_nxt = r_count - 16'd1;
                        w_idx_nxt   = 2'd0;
                        if (r_count == 16'd1) begin
                            w_state_nxt = S_A_HI;
                        end
                    end else begin
                        w_shift_nxt = {r_shift[15:0], rx_data};
                        w_idx_nxt   = r_idx + 2'd1;
                    end
                end
            end
            default: begin
                // DONE and ERR hold until reset.
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_start_state;
            r_hi_byte <= 8'h00;
            r_addr    <= '0;
            r_count   <= 16'h0000;
            r_shift   <= 24'h000000;
            r_idx     <= 2'd0;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_hi_byte <= w_hi_byte_nxt;
            r_addr    <= w_addr_nxt;
            r_count   <= w_count_nxt;
            r_shift   <= w_shift_nxt;
            r_idx     <= w_idx_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    // Registered outputs, decoded from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'h0;
            cpu_rst   <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            rx_ready  <= (w_state_nxt == S_A_HI) || (w_state_nxt == S_A_LO) ||
                         (w_state_nxt == S_C_HI) || (w_state_nxt == S_C_LO) ||
                         (w_state_nxt == S_DATA);
            mem_we    <= w_we_nxt;
            mem_addr  <= w_maddr_nxt;
            mem_wdata <= w_wdata_nxt;
            cpu_rst   <= (w_state_nxt != S_DONE);
            busy      <= (w_state_nxt != S_DONE) && (w_state_nxt != S_ERR);
            done      <= (w_state_nxt == S_DONE);
            err       <= (w_state_nxt == S_ERR);
        end
    end

endmodule
`default_nettype wire
